// File: rtl/fir_ram_arbiter_if.sv
// Shared-BRAM bus bundle for the FIR arbiter: host port, engine port and the RAM side.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface fir_ram_arbiter_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   host_req;
  logic                   host_we;
  logic [pADDR_WIDTH-1:0] host_addr;
  logic [pDATA_WIDTH-1:0] host_wdata;
  logic                   host_gnt;
  logic                   host_rvalid;
  logic [pDATA_WIDTH-1:0] host_rdata;
  logic                   host_werr;

  logic                   eng_req;
  logic                   eng_we;
  logic [pADDR_WIDTH-1:0] eng_addr;
  logic [pDATA_WIDTH-1:0] eng_wdata;
  logic                   eng_gnt;
  logic                   eng_rvalid;
  logic [pDATA_WIDTH-1:0] eng_rdata;
  logic                   eng_busy;

  logic [3:0]             ram_WE;
  logic                   ram_EN;
  logic [pDATA_WIDTH-1:0] ram_Di;
  logic [pADDR_WIDTH-1:0] ram_A;
  logic [pDATA_WIDTH-1:0] ram_Do;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata, host_werr,
    input  eng_req, eng_we, eng_addr, eng_wdata, eng_busy,
    output eng_gnt, eng_rvalid, eng_rdata,
    output ram_WE, ram_EN, ram_Di, ram_A,
    input  ram_Do
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_werr,
    output eng_req, eng_we, eng_addr, eng_wdata, eng_busy,
    input  eng_gnt, eng_rvalid, eng_rdata,
    input  ram_WE, ram_EN, ram_Di, ram_A,
    output ram_Do
  );
endinterface

// File: rtl/fir_ram_arbiter.sv
// Arbitrates host and FIR engine access to one single-port BRAM: round-robin when idle,
// engine priority with a host starvation limit while the FIR runs.
module fir_ram_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int STARVE_LIM  = 8
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst_n,
  fir_ram_arbiter_if.slave     bus
);

  localparam logic [3:0] LP_LIM = 4'(STARVE_LIM);

  logic                   r_last_eng;
  logic [3:0]             r_starve_cnt;
  logic                   r_ram_en;
  logic [3:0]             r_ram_we;
  logic [pADDR_WIDTH-1:0] r_ram_a;
  logic [pDATA_WIDTH-1:0] r_ram_di;
  logic                   r_werr;
  logic                   r_rd1_vld;
  logic                   r_rd1_host;
  logic                   r_rv_host;
  logic                   r_rv_eng;

  logic                   w_host_win;
  logic                   w_host_gnt;
  logic                   w_eng_gnt;
  logic                   w_any_gnt;
  logic                   w_cmd_we;
  logic [pADDR_WIDTH-1:0] w_cmd_addr;
  logic [pDATA_WIDTH-1:0] w_cmd_wdata;
  logic                   w_suppress;

  // Host wins when alone, at the starvation limit under busy, or on its round-robin turn.
  always_comb begin
    w_host_win = 1'b0;
    if (bus.eng_busy)
      w_host_win = bus.host_req && (!bus.eng_req || (r_starve_cnt == LP_LIM));
    else
      w_host_win = bus.host_req && (!bus.eng_req || r_last_eng);
  end

  assign w_host_gnt  = axis_rst_n && w_host_win;
  assign w_eng_gnt   = axis_rst_n && bus.eng_req && !w_host_win;
  assign w_any_gnt   = w_host_gnt || w_eng_gnt;

  assign w_cmd_we    = w_host_gnt ? bus.host_we    : bus.eng_we;
  assign w_cmd_addr  = w_host_gnt ? bus.host_addr  : bus.eng_addr;
  assign w_cmd_wdata = w_host_gnt ? bus.host_wdata : bus.eng_wdata;
  assign w_suppress  = w_host_gnt && bus.host_we && bus.eng_busy;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_last_eng   <= 1'b1;
      r_starve_cnt <= 4'd0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 4'b0000;
      r_ram_a      <= '0;
      r_ram_di     <= '0;
      r_werr       <= 1'b0;
      r_rd1_vld    <= 1'b0;
      r_rd1_host   <= 1'b0;
      r_rv_host    <= 1'b0;
      r_rv_eng     <= 1'b0;
    end else begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 4'b0000;
      r_werr     <= 1'b0;
      r_rd1_vld  <= 1'b0;
      r_rd1_host <= 1'b0;
      r_rv_host  <= r_rd1_vld && r_rd1_host;
      r_rv_eng   <= r_rd1_vld && !r_rd1_host;

      if (w_any_gnt) begin
        r_last_eng <= w_eng_gnt;
        // A host write during a FIR run is accepted on the bus but never reaches the RAM.
        if (w_suppress) begin
          r_werr <= 1'b1;
        end else begin
          r_ram_en   <= 1'b1;
          r_ram_we   <= {4{w_cmd_we}};
          r_ram_a    <= w_cmd_addr;
          r_ram_di   <= w_cmd_wdata;
          r_rd1_vld  <= !w_cmd_we;
          r_rd1_host <= w_host_gnt;
        end
      end

      if (!bus.eng_busy || !bus.host_req || w_host_gnt)
        r_starve_cnt <= 4'd0;
      else if (r_starve_cnt != LP_LIM)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign bus.host_gnt    = w_host_gnt;
  assign bus.eng_gnt     = w_eng_gnt;
  assign bus.ram_EN      = r_ram_en;
  assign bus.ram_WE      = r_ram_we;
  assign bus.ram_A       = r_ram_a;
  assign bus.ram_Di      = r_ram_di;
  assign bus.host_werr   = r_werr;
  assign bus.host_rvalid = r_rv_host;
  assign bus.eng_rvalid  = r_rv_eng;
  assign bus.host_rdata  = r_rv_host ? bus.ram_Do : '0;
  assign bus.eng_rdata   = r_rv_eng  ? bus.ram_Do : '0;

endmodule

// File: tb/tb_fir_ram_arbiter.sv
// Bench for fir_ram_arbiter: BRAM behavioural model, transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fir_ram_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_ram_arbiter_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus();

  fir_ram_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .STARVE_LIM(LIM)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .bus        (bus.slave)
  );

  // BRAM: Do valid the cycle after the address edge
  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] mmem [1024];
  logic [DW-1:0] do_q = '0;
  assign bus.ram_Do = do_q;
  always @(posedge clk) begin
    if (bus.ram_EN) begin
      if (bus.ram_WE == 4'hF) mem[bus.ram_A[AW-1:2]] <= bus.ram_Di;
      do_q <= mem[bus.ram_A[AW-1:2]];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected RAM command for the current cycle and reads pending delivery.
  logic          e_en, e_werr;
  logic [3:0]    e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_di;
  logic          rn_h, rn_e, rx_h, rx_e;
  logic [AW-1:0] rn_a, rx_a;
  logic          m_last_eng;
  int            m_starve;
  logic          xh, xe, own_h, c_we;
  logic [AW-1:0] c_a;
  logic [DW-1:0] c_d, exp_hd, exp_ed;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_host_gnt", 32'(bus.host_gnt), 0);
      chk("rst_eng_gnt", 32'(bus.eng_gnt), 0);
      chk("rst_ram_en", 32'(bus.ram_EN), 0);
      chk("rst_ram_we", 32'(bus.ram_WE), 0);
      chk("rst_ram_a", 32'(bus.ram_A), 0);
      chk("rst_ram_di", bus.ram_Di, 0);
      chk("rst_werr", 32'(bus.host_werr), 0);
      chk("rst_host_rvalid", 32'(bus.host_rvalid), 0);
      chk("rst_eng_rvalid", 32'(bus.eng_rvalid), 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
      chk("rst_eng_rdata", bus.eng_rdata, 0);
      e_en = 0; e_we = 0; e_a = 0; e_di = 0; e_werr = 0;
      rn_h = 0; rn_e = 0; rx_h = 0; rx_e = 0; rn_a = 0; rx_a = 0;
      m_last_eng = 1; m_starve = 0;
    end else begin
      xh = 0; xe = 0;
      if (bus.host_req && !bus.eng_req) xh = 1;
      else if (!bus.host_req && bus.eng_req) xe = 1;
      else if (bus.host_req && bus.eng_req) begin
        xh = bus.eng_busy ? (m_starve >= LIM) : m_last_eng;
        xe = !xh;
      end
      exp_hd = rx_h ? mmem[rx_a[AW-1:2]] : '0;
      exp_ed = rx_e ? mmem[rx_a[AW-1:2]] : '0;
      chk("m_host_gnt", 32'(bus.host_gnt), 32'(xh));
      chk("m_eng_gnt", 32'(bus.eng_gnt), 32'(xe));
      chk("m_ram_en", 32'(bus.ram_EN), 32'(e_en));
      chk("m_ram_we", 32'(bus.ram_WE), 32'(e_we));
      chk("m_ram_a", 32'(bus.ram_A), 32'(e_a));
      chk("m_ram_di", bus.ram_Di, e_di);
      chk("m_werr", 32'(bus.host_werr), 32'(e_werr));
      chk("m_host_rvalid", 32'(bus.host_rvalid), 32'(rx_h));
      chk("m_eng_rvalid", 32'(bus.eng_rvalid), 32'(rx_e));
      chk("m_host_rdata", bus.host_rdata, exp_hd);
      chk("m_eng_rdata", bus.eng_rdata, exp_ed);
      if (e_en && e_we == 4'hF) mmem[e_a[AW-1:2]] = e_di;

      if (bus.eng_busy && bus.host_req && !xh) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else m_starve = 0;

      rx_h = rn_h; rx_e = rn_e; rx_a = rn_a;
      rn_h = 0; rn_e = 0;
      e_en = 0; e_we = 0; e_werr = 0;
      if (xh || xe) begin
        own_h = xh;
        m_last_eng = xe;
        c_we = own_h ? bus.host_we : bus.eng_we;
        c_a  = own_h ? bus.host_addr : bus.eng_addr;
        c_d  = own_h ? bus.host_wdata : bus.eng_wdata;
        if (own_h && c_we && bus.eng_busy) e_werr = 1;
        else begin
          e_en = 1; e_we = c_we ? 4'hF : 4'h0; e_a = c_a; e_di = c_d;
          if (!c_we) begin rn_h = own_h; rn_e = !own_h; rn_a = c_a; end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = 0; bus.eng_wdata = 0; bus.eng_busy = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'hA5A5_0000;
    mem[8] = 32'h1234_5678;
    mem[9] = 32'h0000_0005;
    for (int i = 0; i < 1024; i++) mmem[i] = mem[i];

    // requests held during reset must not be granted
    bus.host_req = 1; bus.eng_req = 1;
    repeat (3) step();
    @(negedge clk);
    chk("d_rst_gnt", 32'({bus.host_gnt, bus.eng_gnt}), 0);

    // host read 0x024 in the first cycle after release
    step();
    rst_n = 1; bus.eng_req = 0; bus.host_req = 1; bus.host_we = 0; bus.host_addr = 12'h024;
    @(negedge clk); chk("d023_gnt", 32'(bus.host_gnt), 1);
    step(); bus.host_req = 0;
    @(negedge clk); chk("d023_en", 32'(bus.ram_EN), 1); chk("d023_a", 32'(bus.ram_A), 32'h024);
    step();
    @(negedge clk); chk("d023_rvalid", 32'(bus.host_rvalid), 1); chk("d023_rdata", bus.host_rdata, 5);

    // engine-only transfer, then tie: host, eng, host, eng
    step(); bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 12'h004;
    step(); bus.host_req = 1; bus.host_addr = 12'h010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d024_rr", 32'({bus.host_gnt, bus.eng_gnt}), (i % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end

    // busy: 8 engine grants then 1 host grant, twice
    bus.eng_busy = 1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("d025_host_gnt", 32'(bus.host_gnt), (i == 8 || i == 17) ? 32'd1 : 32'd0);
      step();
    end

    // host write during busy is suppressed
    bus.eng_req = 0; bus.host_we = 1; bus.host_addr = 12'h020; bus.host_wdata = 32'h0000_00FF;
    @(negedge clk); chk("d026_gnt", 32'(bus.host_gnt), 1);
    step(); bus.host_req = 0; bus.host_we = 0;
    @(negedge clk);
    chk("d026_we", 32'(bus.ram_WE), 0); chk("d026_en", 32'(bus.ram_EN), 0);
    chk("d026_werr", 32'(bus.host_werr), 1);
    step(); bus.eng_busy = 0; bus.host_req = 1;
    step(); bus.host_req = 0;
    step();
    @(negedge clk); chk("d026_rb_valid", 32'(bus.host_rvalid), 1);
    chk("d026_rb_data", bus.host_rdata, 32'h1234_5678);

    // engine reads 0,4,8 back to back; reset drops the last two
    step(); bus.eng_req = 1; bus.eng_addr = 12'h000;
    step(); bus.eng_addr = 12'h004;
    step(); bus.eng_addr = 12'h008;
    @(negedge clk); chk("d027_gnt3", 32'(bus.eng_gnt), 1);
    chk("d027_rv1", 32'(bus.eng_rvalid), 1); chk("d027_rd1", bus.eng_rdata, 32'hA5A5_0000);
    step(); rst_n = 0; bus.eng_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("d027_rst_out", 32'({bus.eng_rvalid, bus.ram_EN, bus.ram_WE, bus.host_werr}), 0);
      chk("d027_rst_a", 32'(bus.ram_A), 0);
      step();
    end
    rst_n = 1; bus.eng_req = 1; bus.eng_addr = 12'h010;
    @(negedge clk); chk("d027_post_gnt", 32'(bus.eng_gnt), 1);
    step(); bus.eng_req = 0;
    repeat (3) step();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.eng_busy = !bus.eng_busy;
      bus.host_req   = ($urandom_range(0, 9) < 6);
      bus.host_we    = ($urandom_range(0, 9) < 3);
      bus.host_addr  = AW'($urandom_range(0, 63) << 2);
      bus.host_wdata = $urandom;
      bus.eng_req    = ($urandom_range(0, 9) < 7);
      bus.eng_we     = ($urandom_range(0, 9) < 3);
      bus.eng_addr   = AW'($urandom_range(0, 63) << 2);
      bus.eng_wdata  = $urandom;
      step();
    end
    bus.host_req = 0; bus.eng_req = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_ram_arbiter.md
FIR_RAM_ARBITER -- requirements
Module: fir_ram_arbiter

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, RAM byte-address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, RAM data width.
REQ-003 SHALL have parameter STARVE_LIM, default 8, max consecutive host-denied cycles while engine busy (range 1..15).
REQ-004 SHALL have ports: axis_clk in 1 clock; axis_rst_n in 1 reset (asynchronous, active-low).
REQ-005 SHALL have ports: host_req in 1, host_we in 1, host_addr in pADDR_WIDTH, host_wdata in pDATA_WIDTH, host_gnt out 1, host_rvalid out 1, host_rdata out pDATA_WIDTH, host_werr out 1.
REQ-006 SHALL have ports: eng_req in 1, eng_we in 1, eng_addr in pADDR_WIDTH, eng_wdata in pDATA_WIDTH, eng_gnt out 1, eng_rvalid out 1, eng_rdata out pDATA_WIDTH, eng_busy in 1 (FIR run in progress).
REQ-007 SHALL have ports: ram_WE out 4, ram_EN out 1, ram_Di out pDATA_WIDTH, ram_A out pADDR_WIDTH, ram_Do in pDATA_WIDTH (single-port BRAM, Do valid the cycle after the address edge).

Function
REQ-008 SHALL transfer a request in any cycle where req && gnt; gnt is combinational from current req and registered arbiter state; at most one of host_gnt/eng_gnt high per cycle.
REQ-009 SHALL register the granted command onto ram_A/ram_Di/ram_WE/ram_EN at the edge ending the transfer cycle N (visible in N+1); ram_EN=1 only in such cycles; ram_WE=4'b1111 for writes, 4'b0000 otherwise.
REQ-010 SHALL, when no command is issued, drive ram_EN=0, ram_WE=0, and hold ram_A/ram_Di.
REQ-011 SHALL assert the owner's rvalid for exactly one cycle at N+2 for a granted read; rdata equals ram_Do in that cycle; no rvalid for writes.
REQ-012 SHALL drive host_rdata/eng_rdata to 0 when the corresponding rvalid is 0.
REQ-013 SHALL sustain one transfer per cycle, back-to-back, with up to two reads in flight (distinct owners allowed).
REQ-014 SHALL, with eng_busy=0, arbitrate round-robin: single requester wins; on simultaneous requests the requester not granted last wins; last_owner resets to engine (host wins first tie).
REQ-015 SHALL, with eng_busy=1, give the engine fixed priority, except when starve_cnt==STARVE_LIM the host wins that cycle.
REQ-016 SHALL keep a 4-bit starve_cnt: increments in cycles with eng_busy && host_req && !host_gnt; clears on host_gnt, on !host_req, or on eng_busy=0; saturates at STARVE_LIM.
REQ-017 SHALL grant a host write while eng_busy=1 but suppress it (ram_EN=0, ram_WE=0 in N+1) and pulse host_werr for one cycle in N+1; host reads during eng_busy complete normally.
REQ-018 SHALL sample eng_busy in the transfer cycle N for REQ-015/REQ-017; a change of eng_busy in N+1 does not affect the issued command.
REQ-019 SHALL not alter address or data (no offset arithmetic); address decode is the requester's responsibility.

Reset
REQ-020 SHALL, while axis_rst_n=0, force host_gnt=eng_gnt=0 and clear ram_EN, ram_WE, ram_A, ram_Di, rvalids, host_werr, starve_cnt, and in-flight read tracking; last_owner=engine.
REQ-021 SHALL discard reads in flight at reset assertion; no rvalid is produced for them after release.
REQ-022 SHALL accept requests in the first cycle after axis_rst_n deasserts.

Verification
REQ-023 Host-only read addr 0x024 with RAM[0x024]=0x0000_0005 -> host_gnt in N, ram_EN=1/ram_A=0x024 in N+1, host_rvalid=1 and host_rdata=0x5 in N+2.
REQ-024 eng_busy=0, both request continuously for 4 cycles -> grants alternate host, eng, host, eng.
REQ-025 eng_busy=1, both request continuously, STARVE_LIM=8 -> 8 engine grants, 1 host grant, repeating; starve_cnt returns to 0 after each host grant.
REQ-026 eng_busy=1, host write 0x0000_00FF to 0x020 -> host_gnt=1, ram_WE=0 and host_werr=1 in N+1, RAM content unchanged on host readback after eng_busy=0.
REQ-027 Engine back-to-back reads 0x000,0x004,0x008 then axis_rst_n low in the cycle after the third grant -> first rvalid delivered, remaining reads dropped, all outputs 0 during reset, next request granted in first cycle after release.
